// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART receiver.
// Register indices, status bit positions and the receiver state encoding.
package uart_pkg;

    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;

    localparam int ST_VALID     = 0;
    localparam int ST_OVERRUN   = 1;
    localparam int ST_FRAME     = 2;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_MSB = 15;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        IDLE_WAIT
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small power-of-two receive FIFO with extra-MSB pointers.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a receive FIFO and DATA/STATUS bus registers.
// Read data is registered and valid the cycle after the access.
module uart_rx #(
    parameter int FREQ       = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        uart_rx_i,
    input  logic        enable_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wvalue_i,
    output logic [31:0] rvalue_o
);

    import uart_pkg::*;

    localparam int CLKS_PER_BIT = FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TW           = $clog2(CLKS_PER_BIT);
    localparam int CW           = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_END = TW'(HALF_BIT - 1);

    logic          sync1;
    logic          rx_s;
    rx_state_t     state;
    rx_state_t     state_next;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          sample_tick;
    logic          push_req;
    logic          frame_set;

    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_rdata;
    logic          overrun;
    logic          frame_err;
    logic          overrun_set;

    logic [1:0]    reg_idx;
    logic          rd_en;
    logic          wr_status;
    logic [31:0]   status_word;
    logic [31:0]   rdata_next;
    logic          unused;

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        sample_tick = 1'b0;
        push_req    = 1'b0;
        frame_set   = 1'b0;
        case (state)
            IDLE:      if (!rx_s) state_next = START;
            START:     if (timer == HALF_END) state_next = rx_s ? IDLE : DATA;
            DATA: begin
                if (timer == BIT_END) begin
                    sample_tick = 1'b1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (timer == BIT_END) begin
                    if (rx_s) begin
                        push_req   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        state_next = IDLE_WAIT;
                    end
                end
            end
            IDLE_WAIT: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            sync1 <= uart_rx_i;
            rx_s  <= sync1;
            state <= state_next;
            if (state_next != state || sample_tick) timer <= '0;
            else                                    timer <= timer + TW'(1);
            if (state_next != state) bit_idx <= '0;
            else if (sample_tick)    bit_idx <= bit_idx + 3'd1;
            if (sample_tick) shift <= {rx_s, shift[7:1]};
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (push_req),
        .pop    (fifo_pop),
        .wdata  (shift),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign reg_idx     = addr_i[3:2];
    assign rd_en       = enable_i && (wstrb_i == 4'b0000);
    assign wr_status   = enable_i && wstrb_i[0] && (reg_idx == UART_REG_STATUS);
    assign fifo_pop    = rd_en && (reg_idx == UART_REG_DATA);
    assign overrun_set = push_req && fifo_full && !fifo_pop;

    always_comb begin
        status_word                            = '0;
        status_word[ST_VALID]                  = !fifo_empty;
        status_word[ST_OVERRUN]                = overrun;
        status_word[ST_FRAME]                  = frame_err;
        status_word[ST_COUNT_MSB:ST_COUNT_LSB] = 8'(fifo_count);
    end

    always_comb begin
        rdata_next = '0;
        case (reg_idx)
            UART_REG_DATA:   if (!fifo_empty) rdata_next = {24'b0, fifo_rdata};
            UART_REG_STATUS: rdata_next = status_word;
            default:         rdata_next = '0;
        endcase
    end

    // A receiver set in the same cycle as a write-1-to-clear keeps the flag at 1.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rvalue_o  <= '0;
        end else begin
            if (overrun_set)                             overrun <= 1'b1;
            else if (wr_status && wvalue_i[ST_OVERRUN])  overrun <= 1'b0;
            if (frame_set)                               frame_err <= 1'b1;
            else if (wr_status && wvalue_i[ST_FRAME])    frame_err <= 1'b0;
            if (rd_en) rvalue_o <= rdata_next;
        end
    end

    assign unused = ^{addr_i[31:4], addr_i[1:0], wvalue_i[31:3], wvalue_i[0]};

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Memory-mapped UART receiver peripheral on the CPU bus, the receive counterpart of the existing UART transmitter.
- Decodes 8N1 serial frames from `uart_rx_i`, stores the bytes in a small FIFO, and exposes data and status registers to the CPU.
- Sits at bus region `addr[31:29] == 3'b011`. The top level gates `enable_i` with the region decode and muxes `rvalue_o` on the previous-cycle address.

Parameters:
- `FREQ`, 27000000, clock frequency in Hz.
- `BAUD`, 115200, line rate in bit/s. `CLKS_PER_BIT = FREQ/BAUD` (234 at defaults); `HALF_BIT = CLKS_PER_BIT/2` (117).
- `FIFO_DEPTH`, 4, receive FIFO entries; must be a power of 2 and ≥2.

Ports:
- `clk_i`  in  1  system clock
- `rstn_i`  in  1  reset, synchronous, active-low
- `uart_rx_i`  in  1  asynchronous serial input, idle high
- `enable_i`  in  1  bus access strobe for this peripheral (region already decoded)
- `wstrb_i`  in  4  byte write strobes; 0 = read
- `addr_i`  in  32  bus address; only `[3:2]` is decoded
- `wvalue_i`  in  32  write data
- `rvalue_o`  out  32  read data, valid the cycle after the access

Behaviour:
- Reset: synchronous to `clk_i`, active while `rstn_i` = 0.
  - Outputs and flags: `rvalue_o` = 0, FIFO empty, overrun = 0, frame_err = 0.
  - Receiver: FSM = IDLE, synchronizer flops = 1.
  - Reset mid-frame abandons the frame; no partial byte is pushed.
- Input path: 2-flop synchronizer, all FSM logic uses the synchronized bit `rx_s`.
- Bit-timer counter width: `$clog2(CLKS_PER_BIT)`; reloaded on every state transition.
- FSM states and transitions:
  - IDLE: `rx_s` = 0 → START, timer = 0.
  - START: at timer = `HALF_BIT`-1, sample. If `rx_s` = 0 → DATA (bit index 0, timer = 0). If `rx_s` = 1 (glitch) → IDLE, nothing pushed.
  - DATA: every `CLKS_PER_BIT` cycles sample `rx_s` into the shift register, LSB first. After bit 7 → STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample.
    - `rx_s` = 1: push byte (or set overrun if the FIFO is full), → IDLE.
    - `rx_s` = 0: set frame_err, discard byte, → IDLE_WAIT.
  - IDLE_WAIT: remain until `rx_s` = 1 (prevents re-triggering on a held-low break), → IDLE.
- FIFO:
  - Storage: read/write pointers of `$clog2(FIFO_DEPTH)`+1 bits; wrap-around via the MSB compare.
  - Count range 0..`FIFO_DEPTH`.
  - Push when full: byte dropped, overrun set, contents unchanged.
  - Pop when empty: no effect.
  - Push and pop in the same cycle: both happen, count unchanged. This includes the full case: the pop frees a slot, so no overrun.
- Register map, by `addr_i[3:2]`:
  - 0 DATA (R): `{24'b0, head byte}`; 0 if empty. A read pops the head.
  - 1 STATUS (R): bit 0 = not empty, bit 1 = overrun, bit 2 = frame_err, bits `[15:8]` = count, others 0.
  - 1 STATUS (W, `wstrb_i[0]`): write-1-to-clear bit 1 and bit 2.
  - 2, 3: read 0, writes ignored.
  - Writes to DATA are ignored.
- Bus timing:
  - An access is a cycle with `enable_i` = 1. A read is an access with `wstrb_i` = 0.
  - On a read, `rvalue_o` is registered at the clock edge and valid in the next cycle. The pop takes effect at that same edge.
  - `rvalue_o` holds its value when there is no read.
  - Back-to-back DATA reads return consecutive FIFO entries.
- Simultaneous flag set (receiver) and W1C clear in the same cycle: set wins, flag stays 1.

Decomposition:
- Package `uart_pkg`:
  - Register index constants `UART_REG_DATA` = 0, `UART_REG_STATUS` = 1.
  - Status bit indices: `ST_VALID` = 0, `ST_OVERRUN` = 1, `ST_FRAME` = 2, count field `[15:8]`.
  - Receiver state enum `rx_state_t` {IDLE, START, DATA, STOP, IDLE_WAIT}.
- One sub-module: `uart_rx_fifo`, parameterised `DEPTH` and `WIDTH`.
  - Ports: `push`, `pop`, `wdata`, `rdata`, `full`, `empty`, `count`.
  - Contains the pointer logic and the push/pop concurrency rules above.
- `uart_rx` contains the synchronizer, FSM and register decode.

Test Plan:
- Frame 0x55 at 234 clk/bit, then read STATUS → `rvalue_o` = 0x0000_0101. Read DATA → 0x55. Read STATUS → 0x0000_0000.
- `uart_rx_i` low for 50 cycles then high → FSM returns to IDLE; STATUS stays 0; no byte pushed.
- Frame 0xA3 with stop bit held low 2 bit-times → STATUS = 0x0000_0004, count 0. Write STATUS `wvalue_i` = 0x4, `wstrb_i` = 0x1 → STATUS = 0.
- Five frames 0x01..0x05 with no reads → STATUS = 0x0000_0403. Four DATA reads return 0x01, 0x02, 0x03, 0x04; the fifth returns 0.
- DATA read in the exact cycle a stop bit completes with the FIFO full → read returns the old head; new byte stored; count stays 4; overrun stays 0.
- Assert `rstn_i` = 0 for 1 cycle during bit 4 of a frame → all flags 0, FIFO empty. The next clean frame 0x7E is received correctly.
